cnn_pool_relu: RTL and testbench

//  Streaming ReLU + 2x2/stride-2 max-pool stage directly downstream of the cnn conv core.

---
 rtl/cnn_pool_relu.sv | 136 +++++++++++++
 tb/tb_cnn_pool_relu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_pool_relu.sv
// rtl/cnn_pool_relu.sv - streaming ReLU followed by 2x2 stride-2 max-pool over raster-ordered maps
module cnn_pool_relu #(
    parameter int M_p = 1,
    parameter int R_p = 4,
    parameter int C_p = 4,
    parameter int W_p = 16
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [W_p-1:0] data_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [W_p-1:0] data_o,
    output logic           last_o,
    output logic           frame_o
);

    localparam int CW = $clog2(C_p);
    localparam int RW = $clog2(R_p);
    localparam int MW = (M_p > 1) ? $clog2(M_p) : 1;
    localparam int LB = C_p / 2;
    localparam int AW = (LB > 1) ? $clog2(LB) : 1;

    generate
        if ((R_p % 2) != 0 || R_p < 2 || (C_p % 2) != 0 || C_p < 2) begin : g_bad_geom
            $error("cnn_pool_relu: R_p and C_p must be even and >= 2");
        end
    endgenerate

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [MW-1:0]  map_q, map_d;
    logic [W_p-1:0] hold_q, hold_d;
    logic [W_p-1:0] data_q, data_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           frame_q, frame_d;

    logic [W_p-1:0] linebuf_q [LB];
    logic           lb_we;
    logic [AW-1:0]  lb_addr;
    logic [W_p-1:0] lb_wdata;
    logic [W_p-1:0] lb_rdata;

    logic           in_beat;
    logic           pix_last;
    logic [W_p-1:0] relu;

    function automatic logic [W_p-1:0] smax(input logic [W_p-1:0] a, input logic [W_p-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign ready_o  = ~valid_q | ready_i;
    assign in_beat  = valid_i & ready_o;
    assign relu     = data_i[W_p-1] ? '0 : data_i;
    assign lb_addr  = AW'(col_q >> 1);
    assign lb_rdata = linebuf_q[lb_addr];
    assign pix_last = (row_q == RW'(R_p - 1)) && (col_q == CW'(C_p - 1));

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        map_d    = map_q;
        hold_d   = hold_q;
        data_d   = data_q;
        valid_d  = valid_q & ~ready_i;
        last_d   = last_q;
        frame_d  = frame_q;
        lb_we    = 1'b0;
        lb_wdata = '0;
        if (in_beat) begin
            if (col_q == CW'(C_p - 1)) begin
                col_d = '0;
                if (row_q == RW'(R_p - 1)) begin
                    row_d = '0;
                    map_d = (map_q == MW'(M_p - 1)) ? '0 : map_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
            // Window phase: top pair folds into the line buffer, bottom pair folds it back out.
            case ({row_q[0], col_q[0]})
                2'b00: hold_d = relu;
                2'b01: begin
                    lb_we    = 1'b1;
                    lb_wdata = smax(hold_q, relu);
                end
                2'b10: hold_d = smax(lb_rdata, relu);
                default: begin
                    data_d  = smax(hold_q, relu);
                    valid_d = 1'b1;
                    last_d  = pix_last;
                    frame_d = pix_last && (map_q == MW'(M_p - 1));
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            col_q   <= '0;
            row_q   <= '0;
            map_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            map_q   <= map_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            frame_q <= frame_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (lb_we) begin
            linebuf_q[lb_addr] <= lb_wdata;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_cnn_pool_relu.sv
// tb/tb_cnn_pool_relu.sv - randomized and directed checks of cnn_pool_relu against a window-max model
module tb_cnn_pool_relu;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        frame;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vi [3];
    logic        ri [3];
    logic [15:0] di [3];
    logic        ro [3];
    logic        vo [3];
    logic        lo [3];
    logic        fo [3];
    logic [15:0] dq [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cnn_pool_relu #(.M_p(1), .R_p(4), .C_p(4), .W_p(16)) u_dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(vi[0]), .ready_o(ro[0]), .data_i(di[0]),
        .valid_o(vo[0]), .ready_i(ri[0]), .data_o(dq[0]), .last_o(lo[0]), .frame_o(fo[0]));

    cnn_pool_relu #(.M_p(2), .R_p(4), .C_p(4), .W_p(16)) u_dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(vi[1]), .ready_o(ro[1]), .data_i(di[1]),
        .valid_o(vo[1]), .ready_i(ri[1]), .data_o(dq[1]), .last_o(lo[1]), .frame_o(fo[1]));

    cnn_pool_relu #(.M_p(3), .R_p(8), .C_p(8), .W_p(16)) u_dut_c (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(vi[2]), .ready_o(ro[2]), .data_i(di[2]),
        .valid_o(vo[2]), .ready_i(ri[2]), .data_o(dq[2]), .last_o(lo[2]), .frame_o(fo[2]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: per map, every 2x2 window's max of clamped-at-zero pixels, raster order.
    task automatic model(input int rows, input int cols, input int maps_per_frame,
                         input logic [15:0] px[$], output beat_t ex[$]);
        int nmaps;
        int v;
        int mx;
        ex.delete();
        nmaps = px.size() / (rows * cols);
        for (int m = 0; m < nmaps; m++) begin
            for (int i = 0; i < rows / 2; i++) begin
                for (int j = 0; j < cols / 2; j++) begin
                    beat_t b;
                    mx = 0;
                    for (int a = 0; a < 2; a++) begin
                        for (int c = 0; c < 2; c++) begin
                            v = int'($signed(px[m*rows*cols + (2*i+a)*cols + 2*j + c]));
                            if (v > mx) mx = v;
                        end
                    end
                    b.data  = 16'(mx);
                    b.last  = (i == rows/2 - 1) && (j == cols/2 - 1);
                    b.frame = b.last && ((m % maps_per_frame) == maps_per_frame - 1);
                    ex.push_back(b);
                end
            end
        end
    endtask

    task automatic run(input string tag, input int d, input logic [15:0] px[$],
                       input int vpct, input int rpct, input int nexp, output beat_t got[$]);
        int   idx = 0;
        int   cyc = 0;
        logic hold_v = 1'b0;
        got.delete();
        while ((idx < px.size() || got.size() < nexp) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            ri[d] = ($urandom_range(99) < rpct);
            if (!hold_v) begin
                vi[d] = (idx < px.size()) && ($urandom_range(99) < vpct);
                di[d] = (idx < px.size()) ? px[idx] : 16'h0;
            end
            #1;
            if (vo[d] && ri[d]) got.push_back({dq[d], lo[d], fo[d]});
            if (vi[d] && ro[d]) idx++;
            hold_v = vi[d] && !ro[d];
        end
        check({tag, ".in_cnt"}, idx, px.size());
        @(negedge clk);
        vi[d] = 1'b0;
        ri[d] = 1'b0;
    endtask

    task automatic compare(input string tag, input beat_t got[$], input beat_t ex[$]);
        check({tag, ".out_cnt"}, got.size(), ex.size());
        for (int k = 0; k < got.size() && k < ex.size(); k++) begin
            check($sformatf("%s[%0d].data", tag, k), got[k].data, ex[k].data);
            check($sformatf("%s[%0d].last", tag, k), got[k].last, ex[k].last);
            check($sformatf("%s[%0d].frame", tag, k), got[k].frame, ex[k].frame);
        end
    endtask

    task automatic ramp(input int start, input int step, input int n, output logic [15:0] q[$]);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(16'(start + k * step));
    endtask

    initial begin
        logic [15:0] px[$];
        logic [15:0] tmp[$];
        beat_t       got[$];
        beat_t       ex[$];

        for (int d = 0; d < 3; d++) begin
            vi[d] = 1'b0;
            ri[d] = 1'b0;
            di[d] = 16'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst%0d.valid_o", d), vo[d], 0);
            check($sformatf("rst%0d.data_o", d), dq[d], 0);
            check($sformatf("rst%0d.last_o", d), lo[d], 0);
            check($sformatf("rst%0d.frame_o", d), fo[d], 0);
            check($sformatf("rst%0d.ready_o", d), ro[d], 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ascending ramp
        ramp(1, 1, 16, px);
        model(4, 4, 1, px, ex);
        run("t1", 0, px, 100, 100, ex.size(), got);
        compare("t1", got, ex);
        if (got.size() == 4) check("t1.first", got[0].data, 6);

        // 2: all negative, then mixed-sign windows
        px.delete();
        for (int k = 0; k < 16; k++) px.push_back(16'(-3));
        model(4, 4, 1, px, ex);
        run("t2a", 0, px, 100, 100, ex.size(), got);
        compare("t2a", got, ex);
        px.delete();
        for (int k = 0; k < 16; k++) px.push_back(16'($urandom));
        px[0] = 16'(-5); px[1] = 16'(-1); px[4] = 16'(-7); px[5] = 16'(-2);
        px[2] = 16'(-4); px[3] = 16'(3);  px[6] = 16'(-9); px[7] = 16'(2);
        px[8] = 16'h8000;
        model(4, 4, 1, px, ex);
        run("t2b", 0, px, 100, 100, ex.size(), got);
        compare("t2b", got, ex);
        if (got.size() >= 2) begin
            check("t2b.w0", got[0].data, 0);
            check("t2b.w1", got[1].data, 3);
        end

        // 3: downstream stalls with the first result held
        ramp(1, 1, 16, px);
        model(4, 4, 1, px, ex);
        ramp(1, 1, 6, tmp);
        run("t3a", 0, tmp, 100, 100, 0, got);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vi[0] = 1'b1;
            di[0] = 16'd7;
            ri[0] = 1'b0;
            #1;
            check("t3.hold_valid", vo[0], 1);
            check("t3.hold_data", dq[0], 6);
            check("t3.hold_ready", ro[0], 0);
        end
        ramp(7, 1, 10, tmp);
        run("t3b", 0, tmp, 100, 100, ex.size(), got);
        compare("t3", got, ex);

        // 5: asynchronous reset in the middle of a map
        ramp(1, 1, 6, tmp);
        run("t5a", 0, tmp, 100, 100, 0, got);
        @(negedge clk);
        vi[0] = 1'b1;
        di[0] = 16'd7;
        #1;
        check("t5.pre_valid", vo[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.async_valid", vo[0], 0);
        check("t5.async_data", dq[0], 0);
        check("t5.async_ready", ro[0], 1);
        @(negedge clk);
        vi[0] = 1'b0;
        rst_n = 1'b1;
        run("t5b", 0, px, 100, 100, ex.size(), got);
        compare("t5", got, ex);

        // 4: two maps per frame
        ramp(1, 1, 16, px);
        ramp(16, -1, 16, tmp);
        px = {px, tmp};
        model(4, 4, 2, px, ex);
        run("t4", 1, px, 100, 100, ex.size(), got);
        compare("t4", got, ex);

        // 6: random gaps and data over two frames of three 8x8 maps
        px.delete();
        for (int k = 0; k < 6 * 64; k++) begin
            if ($urandom_range(15) == 0) px.push_back(16'h8000);
            else px.push_back(16'($urandom));
        end
        model(8, 8, 3, px, ex);
        run("t6", 2, px, 50, 50, ex.size(), got);
        compare("t6", got, ex);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
